// File: rtl/snn_ctrl_pkg.sv
// Shared constants and state encoding for the SNN learning-control blocks.
// Defaults describe a 16-synapse post-neuron timer unit.
package snn_ctrl_pkg;

  localparam int DEF_N_SYN  = 16;
  localparam int DEF_SEL_W  = $clog2(DEF_N_SYN);
  localparam int DEF_SETTLE = 3;

  // Settle counter holds SETTLE-1, and SETTLE never exceeds 15.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } sweep_state_t;

endpackage

// File: rtl/next_set_bit_finder.sv
// Combinational search for the lowest set mask bit at or above a base index.
// When include_base is 0, the base bit itself is skipped.
module next_set_bit_finder
  import snn_ctrl_pkg::*;
#(
  parameter int N_SYN = DEF_N_SYN,
  parameter int SEL_W = DEF_SEL_W
) (
  input  logic [N_SYN-1:0] i_mask,
  input  logic [SEL_W-1:0] i_base,
  input  logic             i_include_base,
  output logic             o_found,
  output logic [SEL_W-1:0] o_index
);

  // Scan downward so the last hit written is the lowest qualifying index.
  always_comb begin
    o_found = 1'b0;
    o_index = '0;
    for (int k = N_SYN - 1; k >= 0; k--) begin
      if (i_mask[k] && ((k > int'(i_base)) || (i_include_base && (k == int'(i_base))))) begin
        o_found = 1'b1;
        o_index = SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/stdp_sweep_sequencer.sv
// Walks select through every enabled synapse and holds each one for SETTLE cycles.
// It then strobes write for one cycle so the timer unit stores the updated weight.
module stdp_sweep_sequencer
  import snn_ctrl_pkg::*;
#(
  parameter int N_SYN  = DEF_N_SYN,
  parameter int SEL_W  = DEF_SEL_W,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [N_SYN-1:0] i_syn_mask,
  input  logic             i_learn_en,
  output logic [SEL_W-1:0] o_select,
  output logic             o_write,
  output logic             o_busy,
  output logic             o_done,
  output logic [SEL_W:0]   o_upd_count
);

  localparam int TALLY_W = SEL_W + 1;

  sweep_state_t       r_state;
  logic [N_SYN-1:0]   r_mask;
  logic [SEL_W-1:0]   r_select;
  logic [CNT_W-1:0]   r_cnt;
  logic [TALLY_W-1:0] r_tally;
  logic [TALLY_W-1:0] r_upd_count;

  sweep_state_t       w_state_next;
  logic [N_SYN-1:0]   w_mask_next;
  logic [SEL_W-1:0]   w_select_next;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [TALLY_W-1:0] w_tally_next;
  logic [TALLY_W-1:0] w_upd_next;
  logic               w_write;
  logic               w_busy;
  logic               w_done;

  logic [N_SYN-1:0]   w_find_mask;
  logic [SEL_W-1:0]   w_find_base;
  logic               w_find_incl;
  logic               w_found;
  logic [SEL_W-1:0]   w_found_idx;

  // In IDLE, search the live input mask from bit 0; otherwise search the captured mask above select.
  assign w_find_mask = (r_state == ST_IDLE) ? i_syn_mask : r_mask;
  assign w_find_base = (r_state == ST_IDLE) ? '0 : r_select;
  assign w_find_incl = (r_state == ST_IDLE);

  next_set_bit_finder #(
    .N_SYN (N_SYN),
    .SEL_W (SEL_W)
  ) u_finder (
    .i_mask         (w_find_mask),
    .i_base         (w_find_base),
    .i_include_base (w_find_incl),
    .o_found        (w_found),
    .o_index        (w_found_idx)
  );

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state     <= ST_IDLE;
      r_mask      <= '0;
      r_select    <= '0;
      r_cnt       <= '0;
      r_tally     <= '0;
      r_upd_count <= '0;
    end else begin
      r_state     <= w_state_next;
      r_mask      <= w_mask_next;
      r_select    <= w_select_next;
      r_cnt       <= w_cnt_next;
      r_tally     <= w_tally_next;
      r_upd_count <= w_upd_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_mask_next   = r_mask;
    w_select_next = r_select;
    w_cnt_next    = r_cnt;
    w_tally_next  = r_tally;
    w_upd_next    = r_upd_count;
    w_write       = 1'b0;
    w_busy        = 1'b0;
    w_done        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_start && !i_abort) begin
          w_mask_next  = i_syn_mask;
          w_tally_next = '0;
          if (w_found) begin
            w_select_next = w_found_idx;
            w_cnt_next    = CNT_W'(SETTLE - 1);
            w_state_next  = ST_SETTLE;
          end else begin
            w_upd_next   = '0;
            w_state_next = ST_DONE;
          end
        end
      end

      ST_SETTLE: begin
        w_busy = 1'b1;
        if (i_abort) begin
          w_state_next = ST_IDLE;
        end else if (r_cnt == '0) begin
          w_state_next = ST_WRITE;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end

      // The completion count is latched on the way into DONE so it is visible alongside done.
      ST_WRITE: begin
        w_busy = 1'b1;
        if (i_abort) begin
          w_state_next = ST_IDLE;
        end else begin
          w_write = i_learn_en;
          if (i_learn_en) begin
            w_tally_next = r_tally + TALLY_W'(1);
          end
          if (w_found) begin
            w_select_next = w_found_idx;
            w_cnt_next    = CNT_W'(SETTLE - 1);
            w_state_next  = ST_SETTLE;
          end else begin
            w_upd_next   = w_tally_next;
            w_state_next = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        w_done       = 1'b1;
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign o_select    = r_select;
  assign o_write     = w_write;
  assign o_busy      = w_busy;
  assign o_done      = w_done;
  assign o_upd_count = r_upd_count;

endmodule
